// File: rtl/mem_port_arbiter_if.sv
// Bundle of IF-stage, MEM-stage and memory-side signals around the unified memory port arbiter.
// master: the arbiter's view; slave: the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic                  flush;
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_valid;
    logic                  if_stall;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_valid;
    logic                  d_stall;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;
    logic [31:0]           perf_if_stall;
    logic [31:0]           perf_d_stall;
    logic [31:0]           perf_txn;

    modport master (
        input  flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_gnt, mem_rvalid, mem_rdata,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               perf_if_stall, perf_d_stall, perf_txn
    );

    modport slave (
        output flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_gnt, mem_rvalid, mem_rdata,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               perf_if_stall, perf_d_stall, perf_txn
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and the MEM stage, one txn at a time.
// Optional performance counters are enabled with the ARB_PERF_EN macro.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    mem_port_arbiter_if.master    bus
);
    localparam int unsigned BeW = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_e;

    state_e              state_q, state_d;
    logic                own_d_q, own_d_d;   // 1: MEM stage owns the transaction
    logic                drop_q, drop_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BeW-1:0]      mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic                d_valid_q, d_valid_d;

    logic d_elig, if_elig, flush_if, mem_req, if_stall, d_stall;

    // A requester retiring this cycle must not be re-issued.
    assign d_elig   = bus.d_req & ~d_valid_q;
    assign if_elig  = bus.if_req & ~if_valid_q & ~bus.flush;
    assign flush_if = bus.flush & ~own_d_q;
    assign mem_req  = (state_q == StIssue);
    assign if_stall = bus.if_req & ~if_valid_q & ~bus.flush;
    assign d_stall  = bus.d_req & ~d_valid_q;

    always_comb begin
        state_d     = state_q;
        own_d_d     = own_d_q;
        drop_d      = drop_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                drop_d = 1'b0;
                if (d_elig) begin
                    own_d_d     = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_be_d    = bus.d_be;
                    state_d     = StIssue;
                end else if (if_elig) begin
                    own_d_d     = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (flush_if) drop_d = 1'b1;
                if (bus.mem_gnt) begin
                    if (own_d_q && mem_we_q) begin
                        state_d   = StIdle;
                        d_valid_d = 1'b1;
                    end else begin
                        state_d = StWaitRsp;
                    end
                end
            end
            StWaitRsp: begin
                if (flush_if) drop_d = 1'b1;
                if (bus.mem_rvalid) begin
                    state_d = StIdle;
                    drop_d  = 1'b0;
                    if (own_d_q) begin
                        d_rdata_d = bus.mem_rdata;
                        d_valid_d = 1'b1;
                    end else if (!(drop_q || bus.flush)) begin
                        if_rdata_d = bus.mem_rdata;
                        if_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            own_d_q     <= 1'b0;
            drop_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_d_q     <= own_d_d;
            drop_q      <= drop_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_stall  = if_stall;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_stall   = d_stall;

`ifdef ARB_PERF_EN
    logic [31:0] perf_if_stall_q, perf_if_stall_d;
    logic [31:0] perf_d_stall_q, perf_d_stall_d;
    logic [31:0] perf_txn_q, perf_txn_d;

    // Only grants of an actually presented request count as transactions.
    always_comb begin
        perf_if_stall_d = perf_if_stall_q + {31'd0, if_stall};
        perf_d_stall_d  = perf_d_stall_q + {31'd0, d_stall};
        perf_txn_d      = perf_txn_q + {31'd0, mem_req & bus.mem_gnt};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_if_stall_q <= '0;
            perf_d_stall_q  <= '0;
            perf_txn_q      <= '0;
        end else begin
            perf_if_stall_q <= perf_if_stall_d;
            perf_d_stall_q  <= perf_d_stall_d;
            perf_txn_q      <= perf_txn_d;
        end
    end

    assign bus.perf_if_stall = perf_if_stall_q;
    assign bus.perf_d_stall  = perf_d_stall_q;
    assign bus.perf_txn      = perf_txn_q;
`else
    assign bus.perf_if_stall = '0;
    assign bus.perf_d_stall  = '0;
    assign bus.perf_txn      = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, contention, delayed store, flushes, async reset, perf.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Memory model: grant after gnt_delay waiting cycles, read data one cycle after grant.
    int unsigned gnt_delay = 0;
    int unsigned wait_cnt;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h100) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | addr;
    endfunction

    assign bus.mem_gnt    = bus.mem_req && (wait_cnt >= gnt_delay);
    assign bus.mem_rvalid = rvalid_q;
    assign bus.mem_rdata  = rdata_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= bus.mem_req & bus.mem_gnt & ~bus.mem_we;
            rdata_q  <= mem_data(bus.mem_addr);
            if (bus.mem_req && !bus.mem_gnt) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
        end
    end

    int gnt_cnt = 0;
    int dstall_cnt = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.mem_req && bus.mem_gnt) gnt_cnt <= gnt_cnt + 1;
            if (bus.d_stall) dstall_cnt <= dstall_cnt + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush   = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_be    = '0;
    endtask

    // Leaves the bench at posedge+1 of an idle cycle, ready to drive cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc();
    endtask

    int g0, s0;

    initial begin
        clear_inputs();
        #2;
        check("rst mem_req", bus.mem_req, 0);
        check("rst d_valid", bus.d_valid, 0);
        check("rst if_rdata", bus.if_rdata, 0);
        check("rst perf_txn", bus.perf_txn, 0);

        // Single load, zero-wait memory
        do_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        #1;
        check("ld c0 mem_req", bus.mem_req, 0);
        check("ld c0 d_stall", bus.d_stall, 1);
        cyc(); #1;
        check("ld c1 mem_req", bus.mem_req, 1);
        check("ld c1 mem_addr", bus.mem_addr, 32'h100);
        check("ld c1 d_stall", bus.d_stall, 1);
        cyc(); #1;
        check("ld c2 mem_req", bus.mem_req, 0);
        check("ld c2 d_stall", bus.d_stall, 1);
        cyc(); #1;
        check("ld c3 d_valid", bus.d_valid, 1);
        check("ld c3 d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        check("ld c3 d_stall", bus.d_stall, 0);
        bus.d_req = 1'b0;
        cyc(); #1;
        check("ld c4 d_valid", bus.d_valid, 0);
        check("ld c4 mem_req", bus.mem_req, 0);

        // Contention: MEM first, IF in the IDLE after d_valid
        do_reset();
        g0 = gnt_cnt; s0 = dstall_cnt;
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        #1;
        check("ct c0 if_stall", bus.if_stall, 1);
        cyc(); #1;
        check("ct c1 mem_req", bus.mem_req, 1);
        check("ct c1 mem_addr", bus.mem_addr, 32'h200);
        cyc();
        cyc(); #1;
        check("ct c3 d_valid", bus.d_valid, 1);
        check("ct c3 d_rdata", bus.d_rdata, 32'hC0DE_0200);
        check("ct c3 if_stall", bus.if_stall, 1);
        bus.d_req = 1'b0;
        cyc(); #1;
        check("ct c4 mem_req", bus.mem_req, 1);
        check("ct c4 mem_addr", bus.mem_addr, 32'h44);
        cyc();
        cyc(); #1;
        check("ct c6 if_valid", bus.if_valid, 1);
        check("ct c6 if_rdata", bus.if_rdata, 32'hC0DE_0044);
        bus.if_req = 1'b0;
        cyc(); cyc(); #1;
        check("ct gnt count", gnt_cnt - g0, 2);
        check("ct d_stall cycles", dstall_cnt - s0, 3);
`ifdef ARB_PERF_EN
        check("perf_txn", bus.perf_txn, 2);
        check("perf_d_stall", bus.perf_d_stall, 3);
        check("perf_d_stall vs measured", bus.perf_d_stall, dstall_cnt - s0);
        check("perf_if_stall", bus.perf_if_stall, 6);
`else
        check("perf_txn off", bus.perf_txn, 0);
        check("perf_d_stall off", bus.perf_d_stall, 0);
        check("perf_if_stall off", bus.perf_if_stall, 0);
`endif

        // Store with grant held off 3 cycles
        gnt_delay = 3;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300;
        bus.d_wdata = 32'h1234_5678; bus.d_be = 4'hF;
        for (int k = 1; k <= 4; k++) begin
            cyc(); #1;
            check($sformatf("st c%0d mem_req", k), bus.mem_req, 1);
            check($sformatf("st c%0d mem_addr", k), bus.mem_addr, 32'h300);
            check($sformatf("st c%0d mem_wdata", k), bus.mem_wdata, 32'h1234_5678);
            check($sformatf("st c%0d mem_we", k), bus.mem_we, 1);
            check($sformatf("st c%0d mem_be", k), bus.mem_be, 4'hF);
            check($sformatf("st c%0d d_valid", k), bus.d_valid, 0);
        end
        cyc(); #1;
        check("st c5 d_valid", bus.d_valid, 1);
        check("st c5 mem_req", bus.mem_req, 0);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        gnt_delay = 0;
        cyc(); #1;
        check("st c6 d_valid", bus.d_valid, 0);
        check("st c6 mem_req", bus.mem_req, 0);

        // Flush in IDLE masks the fetch request
        bus.if_req = 1'b1; bus.if_addr = 32'h60; bus.flush = 1'b1;
        #1;
        check("fi c0 if_stall", bus.if_stall, 0);
        cyc();
        bus.if_req = 1'b0; bus.flush = 1'b0;
        #1;
        check("fi c1 mem_req", bus.mem_req, 0);

        // Flush while the fetch waits for its response
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        cyc(); #1;
        check("ff c1 mem_addr", bus.mem_addr, 32'h40);
        cyc();
        bus.flush = 1'b1;
        #1;
        check("ff c2 if_stall", bus.if_stall, 0);
        cyc();
        bus.flush = 1'b0; bus.if_addr = 32'h80;
        #1;
        check("ff c3 if_valid", bus.if_valid, 0);
        check("ff c3 if_rdata", bus.if_rdata, 32'hC0DE_0044);
        cyc(); #1;
        check("ff c4 mem_req", bus.mem_req, 1);
        check("ff c4 mem_addr", bus.mem_addr, 32'h80);
        cyc();
        cyc(); #1;
        check("ff c6 if_valid", bus.if_valid, 1);
        check("ff c6 if_rdata", bus.if_rdata, 32'hC0DE_0080);
        bus.if_req = 1'b0;

        // Async reset while in WAIT_RSP
        cyc();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        cyc();
        cyc(); #1;
        check("ar c2 mem_req", bus.mem_req, 0);
        bus.d_req = 1'b0;
        rst = 1'b1;
        #1;
        check("ar mem_req", bus.mem_req, 0);
        check("ar mem_addr", bus.mem_addr, 0);
        check("ar d_rdata", bus.d_rdata, 0);
        check("ar if_rdata", bus.if_rdata, 0);
        check("ar d_valid", bus.d_valid, 0);
        check("ar perf_txn", bus.perf_txn, 0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h100;
        cyc(); #1;
        check("ar c1 mem_req", bus.mem_req, 1);
        cyc();
        cyc(); #1;
        check("ar c3 d_valid", bus.d_valid, 1);
        check("ar c3 d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
